// File: rtl/ov7670_pkg.sv
// Shared definitions for the OV7670 pixel-capture path: frame geometry defaults,
// FSM encoding, RGB565->RGB332 packing and the colour-bar palette.
package ov7670_pkg;

  localparam int IMG_W_DEF = 160;
  localparam int IMG_H_DEF = 120;

  typedef enum logic {
    IDLE    = 1'b0,
    CAPTURE = 1'b1
  } state_t;

  // byte1 = R[4:0],G[5:3]; byte2 = G[2:0],B[4:0]. Keep the top bits of each channel.
  function automatic logic [7:0] pack_rgb332(input logic [7:0] byte1, input logic [7:0] byte2);
    return {byte1[7:5], byte1[2:0], byte2[4:3]};
  endfunction

  function automatic logic [7:0] tp_color(input logic [2:0] bar);
    logic [7:0] c;
    case (bar)
      3'd0:    c = 8'hFF;
      3'd1:    c = 8'hFC;
      3'd2:    c = 8'h1F;
      3'd3:    c = 8'h1C;
      3'd4:    c = 8'hE3;
      3'd5:    c = 8'hE0;
      3'd6:    c = 8'h03;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ov7670_edge_det.sv
// Registers a single-bit input and flags its rising and falling edges
// combinationally against the registered copy; RST_VAL sets the registered reset value.
module ov7670_edge_det #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic async_reset,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic q;

  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) q <= RST_VAL;
    else             q <= d;
  end

  assign rise = d & ~q;
  assign fall = ~d & q;

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 capture stage: packs RGB565 byte pairs into RGB332 frame-buffer writes,
// one frame per armed frame start. Define OV7670_TEST_PATTERN_EN for colour bars.
module ov7670_capture
  import ov7670_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int AW    = 15
) (
  input  logic          pclk,
  input  logic          async_reset,
  input  logic          capture_en,
  input  logic          vsync,
  input  logic          href,
  input  logic [7:0]    px_data,
  output logic [AW-1:0] mem_px_addr,
  output logic [7:0]    mem_px_data,
  output logic          px_wr,
  output logic          frame_done,
  output logic          busy
);

  localparam int CW = $clog2(IMG_W + 1);
  localparam int RW = $clog2(IMG_H + 1);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H);

  state_t        state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [AW-1:0] addr;
  logic          phase;
  logic [7:0]    byte1;
  logic [7:0]    pix;
  logic          vsync_rise, vsync_fall, href_rise, href_fall;

  // vsync idles high between frames, so its history register resets to 1.
  ov7670_edge_det #(.RST_VAL(1'b1)) u_vsync_edge (
    .clk         (pclk),
    .async_reset (async_reset),
    .d           (vsync),
    .rise        (vsync_rise),
    .fall        (vsync_fall)
  );

  ov7670_edge_det #(.RST_VAL(1'b0)) u_href_edge (
    .clk         (pclk),
    .async_reset (async_reset),
    .d           (href),
    .rise        (href_rise),
    .fall        (href_fall)
  );

`ifdef OV7670_TEST_PATTERN_EN
  logic [2:0] bar;
  assign bar = 3'((32'(col) * 8) / IMG_W);
  assign pix = tp_color(bar);
`else
  assign pix = pack_rgb332(byte1, px_data);
`endif

  always_ff @(posedge pclk or posedge async_reset) begin
    if (async_reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      px_wr       <= 1'b0;
      mem_px_addr <= '0;
      mem_px_data <= '0;
      addr        <= '0;
      row         <= '0;
      col         <= '0;
      phase       <= 1'b0;
      byte1       <= '0;
    end else begin
      px_wr      <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (vsync_fall && capture_en) begin
            state <= CAPTURE;
            busy  <= 1'b1;
            addr  <= '0;
            row   <= '0;
            col   <= '0;
            phase <= 1'b0;
          end
        end
        CAPTURE: begin
          if (vsync_rise) begin
            state      <= IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end else if (href_fall) begin
            // A trailing odd byte is dropped by clearing the phase here.
            phase <= 1'b0;
            col   <= '0;
            if (row < ROW_MAX) row <= row + 1'b1;
          end else if (href) begin
            if (!phase) begin
              byte1 <= px_data;
              phase <= 1'b1;
              if (href_rise) col <= '0;
            end else begin
              phase <= 1'b0;
              if (col < COL_MAX) col <= col + 1'b1;
              // Out-of-window pixels are consumed but never written.
              if (col < COL_MAX && row < ROW_MAX) begin
                px_wr       <= 1'b1;
                mem_px_addr <= addr;
                mem_px_data <= pix;
                addr        <= addr + 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ov7670_capture.sv
// Directed bench for ov7670_capture on a 2x2 frame: write scoreboard, frame_done
// counting, capture_en gating, overlong lines/frames and mid-line reset.
module tb_ov7670_capture;

  localparam int IMG_W = 2;
  localparam int IMG_H = 2;
  localparam int AW    = 4;
  localparam int EW    = AW + 8;

  logic          pclk = 1'b0;
  logic          async_reset;
  logic          capture_en;
  logic          vsync;
  logic          href;
  logic [7:0]    px_data;
  logic [AW-1:0] mem_px_addr;
  logic [7:0]    mem_px_data;
  logic          px_wr;
  logic          frame_done;
  logic          busy;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  logic [EW-1:0] exp_q[$];

  ov7670_capture #(.IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW)) dut (
    .pclk        (pclk),
    .async_reset (async_reset),
    .capture_en  (capture_en),
    .vsync       (vsync),
    .href        (href),
    .px_data     (px_data),
    .mem_px_addr (mem_px_addr),
    .mem_px_data (mem_px_data),
    .px_wr       (px_wr),
    .frame_done  (frame_done),
    .busy        (busy)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Colour bars for IMG_W=2: col 0 -> bar 0, col 1 -> bar 4.
  function automatic logic [7:0] pick(input int col, input logic [7:0] camera_val);
`ifdef OV7670_TEST_PATTERN_EN
    return (col == 0) ? 8'hFF : 8'hE3;
`else
    return camera_val;
`endif
  endfunction

  // Scoreboard sampled on the falling edge, away from the active edge.
  always @(negedge pclk) begin
    if (async_reset === 1'b0) begin
      if (px_wr === 1'b1) begin
        if (exp_q.size() == 0) check("unexpected_wr", 32'(px_wr), 32'd0);
        else check("wr_addr_data", 32'({mem_px_addr, mem_px_data}), 32'(exp_q.pop_front()));
      end
      if (frame_done === 1'b1) done_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    href    = 1'b1;
    px_data = b;
    tick(1);
  endtask

  task automatic end_line();
    href    = 1'b0;
    px_data = 8'h00;
    tick(3);
  endtask

  task automatic frame_start(input logic en);
    capture_en = en;
    vsync      = 1'b0;
    tick(2);
  endtask

  task automatic frame_end();
    vsync = 1'b1;
    tick(4);
  endtask

  task automatic expect_px(input int addr, input int col, input logic [7:0] camera_val);
    exp_q.push_back({AW'(addr), pick(col, camera_val)});
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_addr"},  32'(mem_px_addr), 32'd0);
    check({tag, "_data"},  32'(mem_px_data), 32'd0);
    check({tag, "_wr"},    32'(px_wr),       32'd0);
    check({tag, "_done"},  32'(frame_done),  32'd0);
    check({tag, "_busy"},  32'(busy),        32'd0);
  endtask

  initial begin
    async_reset = 1'b1;
    capture_en  = 1'b0;
    vsync       = 1'b1;
    href        = 1'b0;
    px_data     = 8'h00;
    tick(3);
    async_reset = 1'b0;
    tick(2);
    check_idle("rst");

    // Frame A: 2x2 of 0xF8,0x1F -> 0xE3 at addr 0..3.
    frame_start(1'b1);
    check("a_busy", 32'(busy), 32'd1);
    for (int ln = 0; ln < 2; ln++) begin
      for (int p = 0; p < 2; p++) begin
        expect_px(ln * 2 + p, p, 8'hE3);
        send_byte(8'hF8);
        send_byte(8'h1F);
      end
      end_line();
    end
    frame_end();
    check("a_done_cnt", 32'(done_cnt), 32'd1);
    check("a_busy_end", 32'(busy), 32'd0);
    check("a_q_empty", 32'(exp_q.size()), 32'd0);

    // Frame B: capture_en low at frame start -> no writes, no done.
    frame_start(1'b0);
    check("b_busy", 32'(busy), 32'd0);
    for (int ln = 0; ln < 2; ln++) begin
      for (int p = 0; p < 4; p++) send_byte(8'hF8 ^ 8'(p));
      end_line();
    end
    frame_end();
    check("b_done_cnt", 32'(done_cnt), 32'd1);

    // Frame C: line of 2*IMG_W+3 bytes, then a normal line, then two extra lines.
    frame_start(1'b1);
    expect_px(0, 0, 8'h0A);
    expect_px(1, 1, 8'hAD);
    send_byte(8'h12); send_byte(8'h34);
    send_byte(8'hAB); send_byte(8'hCD);
    send_byte(8'h55); send_byte(8'h66);
    send_byte(8'h77);
    end_line();
    expect_px(2, 0, 8'h1E);
    expect_px(3, 1, 8'hFF);
    send_byte(8'h0F); send_byte(8'hF0);
    send_byte(8'hE7); send_byte(8'h18);
    end_line();
    for (int ln = 0; ln < 2; ln++) begin
      for (int p = 0; p < 4; p++) send_byte(8'h3C + 8'(p));
      end_line();
    end
    check("c_q_empty", 32'(exp_q.size()), 32'd0);
    frame_end();
    check("c_done_cnt", 32'(done_cnt), 32'd2);

    // Frame D: reset mid-line; upstream enable flop resets with it.
    frame_start(1'b1);
    expect_px(0, 0, 8'hE3);
    send_byte(8'hF8);
    send_byte(8'h1F);
    send_byte(8'h44);
    async_reset = 1'b1;
    capture_en  = 1'b0;
    tick(2);
    check_idle("in_rst");
    async_reset = 1'b0;
    tick(1);
    check_idle("post_rst");
    for (int p = 0; p < 6; p++) send_byte(8'hF8 ^ 8'(p));
    end_line();
    check("d_q_empty", 32'(exp_q.size()), 32'd0);
    frame_end();
    check("d_done_cnt", 32'(done_cnt), 32'd2);

    // Frame E: recovery after reset, addressing restarts at 0.
    frame_start(1'b1);
    expect_px(0, 0, 8'hE3);
    expect_px(1, 1, 8'hE3);
    for (int p = 0; p < 2; p++) begin
      send_byte(8'hF8);
      send_byte(8'h1F);
    end
    end_line();
    frame_end();
    check("e_done_cnt", 32'(done_cnt), 32'd3);
    check("e_q_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ov7670_capture.md
# ov7670_capture

Pixel-capture stage of the OV7670 camera path, sitting directly downstream of the vsync-clocked capture-enable flip-flop. It runs in the camera pclk domain and samples the sensor's RGB565 byte stream (vsync/href/8-bit data). Each byte pair is packed into one RGB332 pixel and written sequentially into the frame buffer's write port. One frame is captured per armed frame start; a done pulse is emitted at frame end.

## Interface
- IMG_W, 160, pixels per captured line
- IMG_H, 120, captured lines per frame
- AW, 15, frame-buffer address width (must hold IMG_W*IMG_H-1)
- pclk  input  1  camera pixel clock; all logic on rising edge
- async_reset  input  1  reset async_reset, asynchronous, active-high
- capture_en  input  1  frame-capture enable (output of the vsync-clocked flip-flop), sampled only at frame start
- vsync  input  1  camera frame sync, high between frames
- href  input  1  camera line valid, high while line bytes are present
- px_data  input  8  camera byte bus
- mem_px_addr  output  AW  frame-buffer write address
- mem_px_data  output  8  RGB332 pixel {R[2:0],G[2:0],B[1:0]}
- px_wr  output  1  frame-buffer write strobe, one pclk per pixel
- frame_done  output  1  one-pclk pulse at end of a captured frame
- busy  output  1  high while in CAPTURE

## Operation
- States: IDLE, CAPTURE. Reset -> IDLE.
- vsync_d is vsync registered once. A frame start is vsync_d=1 & vsync=0.
- IDLE -> CAPTURE on frame start with capture_en=1. On entry: addr counter=0, row=0, col=0, byte phase=0.
- A frame start with capture_en=0 leaves the block in IDLE, with no writes.
- CAPTURE, href=1, phase 0: latch byte1 = px_data; phase <= 1.
- CAPTURE, href=1, phase 1: form pixel {byte1[7:5], byte1[2:0], px_data[4:3]}; phase <= 0; col += 1.
  - Write only if col<IMG_W and row<IMG_H: px_wr=1, mem_px_addr=addr, addr += 1.
  - Otherwise the pixel is dropped: px_wr=0 and addr is unchanged.
- href falling edge (href_d=1, href=0) in CAPTURE: phase <= 0 (an odd trailing byte is discarded); col <= 0; row += 1, saturating at IMG_H.
- CAPTURE -> IDLE on vsync rising edge (vsync_d=0, vsync=1), pulsing frame_done. This is independent of how many pixels were written, so short frames leave the remainder of the buffer stale.
- Addresses never exceed IMG_W*IMG_H-1. addr wraps to 0 only at the next frame start.
- href is ignored in IDLE.
- async_reset mid-frame returns the block to IDLE immediately; the next capture waits for a fresh frame start.

## Timing
- Reset values: mem_px_addr=0, mem_px_data=0, px_wr=0, frame_done=0, busy=0; all internal counters and phase = 0; vsync_d=1, href_d=0.
- All outputs are registered. px_wr, mem_px_data and mem_px_addr become valid after the pclk edge that samples byte 2, and stay valid for exactly one cycle.
- Maximum write rate: one write per 2 pclk.
- frame_done is asserted for the single cycle after the edge that detects vsync rising. busy deasserts on that same edge.
- Frame-start detection lags vsync by one pclk. The first href is at least 1 pclk after the vsync fall, so no byte is lost.
- If a frame start and a vsync rise are both detected in the same cycle (glitch), frame start takes priority.

## Configuration
- OV7670_TEST_PATTERN_EN defined: the pixel value is replaced by 8 vertical color bars, bar = col*8/IMG_W, using the fixed palette 0xFF, 0xFC, 0x1F, 0x1C, 0xE3, 0xE0, 0x03, 0x00. Timing, addressing and strobes are unchanged, and px_data is ignored.
- OV7670_TEST_PATTERN_EN undefined: camera data is packed as described under Operation.

## Structure
- Shared package ov7670_pkg: IMG_W/IMG_H defaults, state encoding (IDLE, CAPTURE), RGB565-to-RGB332 packing function, test-pattern palette constants.
- One sub-module: ov7670_edge_det. It registers an input and produces rise and fall pulses with a reset value parameter. It is instantiated for vsync (reset 1) and href (reset 0).

## Test plan
- Reset asserted mid-line, then released -> all outputs 0 and busy=0. href activity before the next vsync fall produces no px_wr.
- capture_en=1, one 2x2 frame (IMG_W=2, IMG_H=2), bytes 0xF8,0x1F per pixel -> 4 writes of 0xE3 at addr 0..3, then a frame_done pulse after vsync rises.
- capture_en=0 at vsync fall, full frame driven -> zero px_wr and no frame_done.
- Line with 2*IMG_W+3 bytes -> exactly IMG_W writes on that line. The odd byte is discarded and the next line's first write is at addr = row*IMG_W.
- More than IMG_H lines per frame -> no writes once addr reaches IMG_W*IMG_H-1, and frame_done fires once.
- OV7670_TEST_PATTERN_EN defined, IMG_W=160 -> col 0 writes 0xFF, col 20 writes 0xFC, col 159 writes 0x00.
